fa_bist: RTL and testbench
==========================

FA_BIST -- requirements
Module: fa_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the number of cycles each vector is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the only clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE and DONE.
REQ-005 SHALL have ports a, b, c  output  1 each  stimulus to the full adder under test, with {a,b,c} equal to the vector index.
REQ-006 SHALL have port carry  input  1  carry returned by the full adder under test.
REQ-007 SHALL have port out  input  1  sum returned by the full adder under test.
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port done  output  1  high (level) in DONE until the next start or reset.
REQ-010 SHALL have port pass  output  1  high in DONE only if err_count is 0.
REQ-011 SHALL have port err_count  output  4  number of mismatching vectors in the current or last run.

Function
REQ-012 SHALL implement FSM states IDLE, APPLY, CHECK and DONE.
REQ-013 IDLE with start=1 SHALL go to APPLY, set vec=0, clear err_count, set busy=1; with start=0 it SHALL stay in IDLE.
REQ-014 APPLY SHALL drive {a,b,c}=vec registered, hold it exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-015 CHECK SHALL keep {a,b,c} unchanged and compare on its closing edge: expected out = a^b^c; expected carry = (a&b)|(a&c)|(b&c).
REQ-016 A mismatch on carry or out (or both) SHALL add exactly 1 to err_count for that vector.
REQ-017 CHECK with vec=7 SHALL go to DONE; otherwise it SHALL go to APPLY with vec+1.
REQ-018 Total run latency SHALL be 8*(SETTLE_CYCLES+1) cycles from the edge sampling start to done=1.
REQ-019 err_count SHALL never exceed 8; no saturation logic is needed.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 DONE with start=1 SHALL restart as in REQ-013, clearing done, pass and err_count on the same edge.
REQ-022 {a,b,c} SHALL be 000 in IDLE and SHALL hold 111 in DONE.
REQ-023 All outputs SHALL be registered, with no combinational path from carry or out to any output.

Reset
REQ-024 reset=1 SHALL, on the next rising clk, force IDLE with vec=0, a=b=c=0, busy=0, done=0, pass=0 and err_count=0.
REQ-025 reset SHALL take priority over start and over any state, including mid-run; a later start SHALL begin a fresh run from vec 0.

Configuration
REQ-026 When macro FA_BIST_FIRST_FAIL_EN is defined, the block SHALL add outputs fail_valid (1) and fail_vec (3), reset to 0.
REQ-027 With FA_BIST_FIRST_FAIL_EN defined, fail_vec SHALL capture the index of the first mismatching vector in a run, fail_valid SHALL set with it, both SHALL hold until the next start or reset, and later mismatches SHALL not overwrite them.
REQ-028 Without FA_BIST_FIRST_FAIL_EN, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario 1: golden full adder, SETTLE_CYCLES=1, one-cycle start pulse -> a,b,c sweep 000..111, each held 2 cycles; done=1 16 cycles after start; err_count=0; pass=1.
REQ-030 Scenario 2: out stuck at 0 -> err_count=4 (vectors 1,2,4,7); pass=0; with the macro defined, fail_vec=1 and fail_valid=1.
REQ-031 Scenario 3: carry inverted -> err_count=8; pass=0; with the macro defined, fail_vec=0.
REQ-032 Scenario 4: start held high for the whole run -> exactly one run with 16-cycle latency; then reset asserted 1 cycle at vec=3 of a new run -> next cycle IDLE, a=b=c=0, busy=0, err_count=0.
REQ-033 Scenario 5: SETTLE_CYCLES=3 with golden adder -> done 32 cycles after start; start in DONE clears done/pass next edge and re-runs with pass=1.

Source files
------------

// File: rtl/fa_bist.sv
// Built-in self test for a single full adder: sweeps {a,b,c} over 0..7 and counts
// vectors whose returned sum/carry disagree. Define FA_BIST_FIRST_FAIL_EN to add first-failure capture.
module fa_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       carry,
  input  logic       out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count
`ifdef FA_BIST_FIRST_FAIL_EN
  ,
  output logic       fail_valid,
  output logic [2:0] fail_vec
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
`ifdef FA_BIST_FIRST_FAIL_EN
  logic       fval_q, fval_d;
  logic [2:0] fvec_q, fvec_d;
`endif

  // Expected response is derived from the registered vector, so outputs never see carry/out combinationally.
  logic exp_out, exp_carry, mism;
  assign exp_out   = ^vec_q;
  assign exp_carry = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  assign mism      = (out != exp_out) || (carry != exp_carry);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef FA_BIST_FIRST_FAIL_EN
    fval_d  = fval_q;
    fvec_d  = fvec_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          vec_d   = 3'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef FA_BIST_FIRST_FAIL_EN
          fval_d  = 1'b0;
          fvec_d  = 3'd0;
`endif
        end
      end
      APPLY: begin
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      CHECK: begin
        err_d = err_q + {3'b000, mism};
`ifdef FA_BIST_FIRST_FAIL_EN
        if (mism && !fval_q) begin
          fval_d = 1'b1;
          fvec_d = vec_q;
        end
`endif
        if (vec_q == 3'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = APPLY;
          vec_d   = vec_q + 3'd1;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef FA_BIST_FIRST_FAIL_EN
      fval_q  <= 1'b0;
      fvec_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef FA_BIST_FIRST_FAIL_EN
      fval_q  <= fval_d;
      fvec_q  <= fvec_d;
`endif
    end
  end

  assign {a, b, c}  = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
`ifdef FA_BIST_FIRST_FAIL_EN
  assign fail_valid = fval_q;
  assign fail_vec   = fvec_q;
`endif

endmodule

// File: tb/tb_fa_bist.sv
// Self-checking bench for fa_bist: two instances (SETTLE_CYCLES 1 and 3) driven by a
// fault-injectable full adder model and checked cycle by cycle against a sweep model.
module tb_fa_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic       a0, b0, c0, carry0, out0, busy0, done0, pass0;
  logic       a1, b1, c1, carry1, out1, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic       fv0, fv1;
  logic [2:0] fvec0, fvec1;

  int         mode;
  logic [7:0] mask_o, mask_c;
  int         nassert = 0;
  int         nfail   = 0;

  // Adder under test: 0 golden, 1 sum stuck at 0, 2 carry inverted, 3 random per-vector flips.
  function automatic logic [1:0] adder(input logic [2:0] v, input int md,
                                       input logic [7:0] mo, input logic [7:0] mc);
    int   n;
    logic co, so;
    n  = $countones(v);
    co = (n >= 2);
    so = n[0];
    case (md)
      1: so = 1'b0;
      2: co = ~co;
      3: begin so = so ^ mo[v]; co = co ^ mc[v]; end
      default: ;
    endcase
    return {co, so};
  endfunction

  function automatic bit bad(input int v);
    logic [2:0] vv;
    int         n;
    vv = v[2:0];
    n  = $countones(vv);
    return adder(vv, mode, mask_o, mask_c) != {1'(n >= 2), n[0]};
  endfunction

  assign {carry0, out0} = adder({a0, b0, c0}, mode, mask_o, mask_c);
  assign {carry1, out1} = adder({a1, b1, c1}, mode, mask_o, mask_c);

  fa_bist #(.SETTLE_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .carry(carry0), .out(out0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef FA_BIST_FIRST_FAIL_EN
    , .fail_valid(fv0), .fail_vec(fvec0)
`endif
  );

  fa_bist #(.SETTLE_CYCLES(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .carry(carry1), .out(out1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef FA_BIST_FIRST_FAIL_EN
    , .fail_valid(fv1), .fail_vec(fvec1)
`endif
  );

`ifndef FA_BIST_FIRST_FAIL_EN
  assign fv0 = 1'b0; assign fvec0 = 3'd0;
  assign fv1 = 1'b0; assign fvec1 = 3'd0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nassert++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // k = number of edges after the one that sampled start; P = SETTLE_CYCLES+1.
  task automatic chk_inst(input string nm, input int k, input int p,
                          input logic [2:0] abc, input logic bsy, input logic dn,
                          input logic ps, input logic [3:0] err,
                          input logic fv, input logic [2:0] fvec);
    int         nv, e, first;
    logic [2:0] ev;
    nv    = k / p;
    if (nv > 8) nv = 8;
    e     = 0;
    first = -1;
    for (int v = 0; v < nv; v++)
      if (bad(v)) begin
        e++;
        if (first < 0) first = v;
      end
    ev = (k < 8 * p) ? 3'(k / p) : 3'd7;
    chk({nm, " abc"},  8'(abc), 8'(ev));
    chk({nm, " busy"}, 8'(bsy), 8'(k < 8 * p));
    chk({nm, " done"}, 8'(dn),  8'(k >= 8 * p));
    chk({nm, " pass"}, 8'(ps),  8'((k >= 8 * p) && (e == 0)));
    chk({nm, " err"},  8'(err), 8'(e));
`ifdef FA_BIST_FIRST_FAIL_EN
    chk({nm, " fail_valid"}, 8'(fv),   8'(first >= 0));
    chk({nm, " fail_vec"},   8'(fvec), (first >= 0) ? 8'(first) : 8'd0);
`endif
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " u0 abc"},  8'({a0, b0, c0}), 8'd0);
    chk({nm, " u0 busy"}, 8'(busy0), 8'd0);
    chk({nm, " u0 done"}, 8'(done0), 8'd0);
    chk({nm, " u0 pass"}, 8'(pass0), 8'd0);
    chk({nm, " u0 err"},  8'(err0),  8'd0);
    chk({nm, " u1 abc"},  8'({a1, b1, c1}), 8'd0);
    chk({nm, " u1 busy"}, 8'(busy1), 8'd0);
    chk({nm, " u1 done"}, 8'(done1), 8'd0);
    chk({nm, " u1 err"},  8'(err1),  8'd0);
`ifdef FA_BIST_FIRST_FAIL_EN
    chk({nm, " u0 fail_valid"}, 8'(fv0), 8'd0);
    chk({nm, " u0 fail_vec"},   8'(fvec0), 8'd0);
`endif
  endtask

  // One full run on both instances; hold keeps start high until just before u0 finishes.
  task automatic do_run(input bit hold);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      chk_inst("u0", k, 2, {a0, b0, c0}, busy0, done0, pass0, err0, fv0, fvec0);
      chk_inst("u1", k, 4, {a1, b1, c1}, busy1, done1, pass1, err1, fv1, fvec1);
      if (hold && k == 15) start = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    mode   = 0;
    mask_o = 8'h00;
    mask_c = 8'h00;
    tick();
    tick();
    chk_idle("reset with start");
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk_idle("idle no start");

    mode = 0; do_run(1'b0);
    mode = 1; do_run(1'b0);
    mode = 2; do_run(1'b0);
    mode = 0; do_run(1'b1);

    for (int i = 0; i < 6; i++) begin
      mode   = int'($urandom_range(0, 3));
      mask_o = 8'($urandom);
      mask_c = 8'($urandom);
      do_run(1'($urandom_range(0, 1)));
    end

    // Abort a faulty run mid-sweep, then confirm the next run starts clean.
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mid-run u0 abc", 8'({a0, b0, c0}), 8'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("mid-run reset");
    tick();
    chk_idle("after reset idle");
    mode = 0;
    do_run(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
